// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//
// Turns a raster-order pixel stream into serialized 3x3 convolution taps
// for a downstream multiply-accumulate unit.
//
// Each accepted pixel shifts into two row line buffers and a 3x3 window.
// When the accepted pixel completes a full window (row >= 2, col >= 2),
// the sequencer stops accepting pixels and emits the nine window taps,
// one per cycle, each paired with its kernel weight. Weights come from a
// shadow copy taken when the window starts, so weight writes made during
// serialization only affect later windows.
//
// Parameters
//   IMG_W   pixels per image row (3..1024)
//   DATA_W  pixel and weight width
//
// Ports
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   pix_in       incoming raster-order pixel
//   pix_valid    pix_in valid
//   frame_start  accepted pixel is row 0, col 0 of a new frame
//   pix_ready    sequencer can accept a pixel this cycle
//   wgt_we       kernel weight write strobe
//   wgt_addr     kernel tap index 0..8 (9..15 ignored)
//   wgt_data     weight value
//   act_out      activation operand to the MAC
//   wgt_out      weight operand to the MAC
//   mac_valid    act_out/wgt_out valid this cycle
//   mac_first    tap 0 of a window (consumer restarts its sum)
//   mac_last     tap 8 of a window (sum complete after this cycle)
//   busy         window serialization in progress

module conv_window_sequencer #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              frame_start,
    output logic              pix_ready,
    input  logic              wgt_we,
    input  logic [3:0]        wgt_addr,
    input  logic [DATA_W-1:0] wgt_data,
    output logic [DATA_W-1:0] act_out,
    output logic [DATA_W-1:0] wgt_out,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              busy
);

    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_MAX = 1023;

    typedef enum logic {
        IDLE,
        SERIAL
    } state_t;

    state_t state, state_next;
    logic [3:0] k, k_next;

    // Position counters: col/row of the next pixel to be accepted.
    logic [COL_W-1:0] col, col_next, pos_col;
    logic [9:0]       row, row_next, pos_row;

    logic accept;
    logic win_fire;

    // lb1 holds the previous row, lb2 the row before that, indexed by column.
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    // win[r][c]: r = 0 oldest row, c = 0 oldest column.
    logic [DATA_W-1:0] win      [3][3];
    logic [DATA_W-1:0] win_flat [9];

    logic [DATA_W-1:0] wgt    [9];
    logic [DATA_W-1:0] shadow [9];

    // ------------------------------------------------------------------
    // Acceptance and position of the accepted pixel
    // ------------------------------------------------------------------
    assign accept  = pix_valid && pix_ready;

    // frame_start relocates the accepted pixel to (0,0) before anything
    // (line-buffer index, window test, counter advance) looks at it.
    assign pos_col = frame_start ? '0 : col;
    assign pos_row = frame_start ? '0 : row;

    assign win_fire = accept && (pos_row >= 10'd2) && (pos_col >= COL_W'(2));

    assign lb1_rd = lb1[pos_col];
    assign lb2_rd = lb2[pos_col];

    always_comb begin
        col_next = pos_col;
        row_next = pos_row;
        if (pos_col == COL_W'(IMG_W - 1)) begin
            col_next = '0;
            if (pos_row != 10'(ROW_MAX)) begin
                row_next = pos_row + 10'd1;
            end
        end else begin
            col_next = pos_col + COL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= col_next;
            row <= row_next;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and window (contents never reach the output until a
    // full window of current-frame pixels has been shifted in)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[pos_col] <= lb1_rd;
            lb1[pos_col] <= pix_in;
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= pix_in;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            win_flat[i] = win[i / 3][i % 3];
        end
    end

    // ------------------------------------------------------------------
    // Kernel weights and the per-window shadow copy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 9; i++) begin
                wgt[i] <= '0;
            end
        end else if (wgt_we) begin
            for (int unsigned i = 0; i < 9; i++) begin
                if (wgt_addr == 4'(i)) begin
                    wgt[i] <= wgt_data;
                end
            end
        end
    end

    // The shadow captures the weights as they stand before any write made
    // on the same edge that starts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 9; i++) begin
                shadow[i] <= '0;
            end
        end else if (win_fire) begin
            for (int unsigned i = 0; i < 9; i++) begin
                shadow[i] <= wgt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialization FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    always_comb begin
        state_next = state;
        k_next     = k;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        mac_valid  = 1'b0;
        mac_first  = 1'b0;
        mac_last   = 1'b0;
        act_out    = '0;
        wgt_out    = '0;

        case (state)
            IDLE: begin
                pix_ready = 1'b1;
                k_next    = '0;
                if (win_fire) begin
                    state_next = SERIAL;
                end
            end
            SERIAL: begin
                busy      = 1'b1;
                mac_valid = 1'b1;
                mac_first = (k == 4'd0);
                mac_last  = (k == 4'd8);
                for (int unsigned i = 0; i < 9; i++) begin
                    if (k == 4'(i)) begin
                        act_out = win_flat[i];
                        wgt_out = shadow[i];
                    end
                end
                if (k == 4'd8) begin
                    state_next = IDLE;
                    k_next     = '0;
                end else begin
                    k_next = k + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer
//
// Randomized and directed stimulus for conv_window_sequencer (IMG_W=4),
// compared cycle by cycle against a reference model that stores the frame
// as a 2-D image array and keeps a queue of expected MAC taps.

module tb_conv_window_sequencer;

    localparam int IMG_W  = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              frame_start;
    logic              pix_ready;
    logic              wgt_we;
    logic [3:0]        wgt_addr;
    logic [DATA_W-1:0] wgt_data;
    logic [DATA_W-1:0] act_out;
    logic [DATA_W-1:0] wgt_out;
    logic              mac_valid;
    logic              mac_first;
    logic              mac_last;
    logic              busy;

    conv_window_sequencer #(
        .IMG_W (IMG_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .pix_ready  (pix_ready),
        .wgt_we     (wgt_we),
        .wgt_addr   (wgt_addr),
        .wgt_data   (wgt_data),
        .act_out    (act_out),
        .wgt_out    (wgt_out),
        .mac_valid  (mac_valid),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [DATA_W-1:0] act;
        logic [DATA_W-1:0] wgt;
        logic              first;
        logic              last;
    } tap_t;

    tap_t              exp_q[$];
    logic [DATA_W-1:0] img [0:1023][0:IMG_W-1];
    logic [DATA_W-1:0] mw  [9];
    int                mr, mc;

    int errors = 0;
    int checks = 0;

    // Observation hooks for the directed scenarios.
    int                mac_count;
    logic [DATA_W-1:0] cap_act[$];
    logic [DATA_W-1:0] cap_w4[$];
    bit                w37_pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 9; i++) mw[i] = '0;
        mr = 0;
        mc = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // advance the model by one edge, then move to the next falling edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] p, input bit fs,
                        input bit we, input logic [3:0] a, input logic [DATA_W-1:0] d,
                        output bit acc);
        int   pr, pc;
        tap_t t;
        pix_valid   = v;
        pix_in      = p;
        frame_start = fs;
        wgt_we      = we;
        wgt_addr    = a;
        wgt_data    = d;
        #1;
        if (exp_q.size() == 0) begin
            check("pix_ready", 32'(pix_ready), 32'd1);
            check("busy", 32'(busy), 32'd0);
            check("mac_valid", 32'(mac_valid), 32'd0);
            check("mac_first", 32'(mac_first), 32'd0);
            check("mac_last", 32'(mac_last), 32'd0);
            check("act_idle", 32'(act_out), 32'd0);
            check("wgt_idle", 32'(wgt_out), 32'd0);
        end else begin
            t = exp_q[0];
            check("pix_ready", 32'(pix_ready), 32'd0);
            check("busy", 32'(busy), 32'd1);
            check("mac_valid", 32'(mac_valid), 32'd1);
            check("mac_first", 32'(mac_first), 32'(t.first));
            check("mac_last", 32'(mac_last), 32'(t.last));
            check("act_out", 32'(act_out), 32'(t.act));
            check("wgt_out", 32'(wgt_out), 32'(t.wgt));
            if (exp_q.size() == 5) cap_w4.push_back(wgt_out);
        end
        if (mac_valid) begin
            mac_count++;
            cap_act.push_back(act_out);
        end

        acc = v && (exp_q.size() == 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
            pr = fs ? 0 : mr;
            pc = fs ? 0 : mc;
            img[pr][pc] = p;
            if (pr >= 2 && pc >= 2) begin
                for (int j = 0; j < 9; j++) begin
                    t.act   = img[pr - 2 + j / 3][pc - 2 + j % 3];
                    t.wgt   = mw[j];
                    t.first = (j == 0);
                    t.last  = (j == 8);
                    exp_q.push_back(t);
                end
            end
            if (pc == IMG_W - 1) begin
                mc = 0;
                mr = (pr < 1023) ? pr + 1 : 1023;
            end else begin
                mc = pc + 1;
                mr = pr;
            end
        end
        if (we && a < 9) mw[a] = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        bit acc;
        step(1'b0, '0, 1'b0, 1'b0, 4'd0, '0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Feed n pixels with pix_valid held high; sequential values from base
    // when seq is set, random otherwise.
    task automatic feed(input int n, input bit fs_first, input bit seq, input int base);
        int  cnt = 0;
        bit  acc;
        bit  we;
        logic [DATA_W-1:0] p;
        for (int cyc = 0; cyc < n * 12 + 10 && cnt < n; cyc++) begin
            p  = seq ? DATA_W'(base + cnt) : DATA_W'($urandom);
            we = w37_pending && (exp_q.size() == 7);
            if (we) w37_pending = 1'b0;
            step(1'b1, p, fs_first && cnt == 0, we, 4'd4, 8'h80, acc);
            if (acc) cnt++;
        end
        check("feed_count", 32'(cnt), 32'(n));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] exp35[9];

    initial begin
        bit acc;
        exp35 = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
        reset = 1'b1;
        pix_valid = 1'b0; pix_in = '0; frame_start = 1'b0;
        wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0;
        w37_pending = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mac_valid", 32'(mac_valid), 32'd0);
        check("rst_act", 32'(act_out), 32'd0);
        check("rst_wgt", 32'(wgt_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Known 4-wide frame with all-ones kernel.
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1, 4'(i), 8'd1, acc);
        mac_count = 0;
        cap_act.delete();
        feed(16, 1'b1, 1'b1, 1);
        drain();
        check("req035_mac_cycles", 32'(mac_count), 32'd36);
        if (cap_act.size() >= 9) begin
            for (int j = 0; j < 9; j++) check("req035_tap", 32'(cap_act[j]), 32'(exp35[j]));
        end else begin
            check("req035_cap_size", 32'(cap_act.size()), 32'd9);
        end

        // Weight write during tap 2 of a window.
        cap_w4.delete();
        w37_pending = 1'b1;
        feed(8, 1'b0, 1'b0, 0);
        drain();
        if (cap_w4.size() >= 2) begin
            check("req037_old_w4", 32'(cap_w4[0]), 32'd1);
            check("req037_new_w4", 32'(cap_w4[1]), 32'h80);
        end else begin
            check("req037_cap_size", 32'(cap_w4.size()), 32'd2);
        end

        // Frame restart at row 3, col 1.
        feed(13, 1'b1, 1'b0, 0);
        drain();
        mac_count = 0;
        feed(10, 1'b1, 1'b0, 0);
        drain();
        check("req038_no_mac", 32'(mac_count), 32'd0);
        feed(1, 1'b0, 1'b0, 0);
        drain();
        check("req038_window", 32'(mac_count), 32'd9);

        // Reset in the middle of tap 5.
        feed(1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12 && exp_q.size() != 4; i++) idle_step();
        check("req039_at_tap5", 32'(exp_q.size()), 32'd4);
        reset = 1'b1;
        #1;
        check("req039_mac_valid", 32'(mac_valid), 32'd0);
        check("req039_busy", 32'(busy), 32'd0);
        check("req039_act", 32'(act_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle_step();
        feed(12, 1'b1, 1'b0, 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1, 4'(i), DATA_W'($urandom), acc);
        step(1'b1, DATA_W'($urandom), 1'b1, 1'b0, 4'd0, '0, acc);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step($urandom_range(0, 3) != 0, DATA_W'($urandom),
                 $urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                 4'($urandom_range(0, 15)), DATA_W'($urandom), acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 Parameter IMG_W, default 64, pixels per image row (range 3..1024).
REQ-002 Parameter DATA_W, default 8, pixel and weight width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pix_in  input  DATA_W  incoming raster-order pixel.
REQ-006 pix_valid  input  1  pix_in valid.
REQ-007 frame_start  input  1  marks accepted pixel as row 0, col 0 of a new frame.
REQ-008 pix_ready  output  1  sequencer can accept a pixel this cycle.
REQ-009 wgt_we  input  1  kernel weight write strobe.
REQ-010 wgt_addr  input  4  kernel tap index 0..8.
REQ-011 wgt_data  input  DATA_W  weight value.
REQ-012 act_out  output  DATA_W  activation operand to MAC.
REQ-013 wgt_out  output  DATA_W  weight operand to MAC.
REQ-014 mac_valid  output  1  act_out/wgt_out valid this cycle.
REQ-015 mac_first  output  1  tap 0 of a window; consumer restarts its sum.
REQ-016 mac_last  output  1  tap 8 of a window; consumer's sum is complete after this cycle.
REQ-017 busy  output  1  window serialization in progress.

Function
REQ-018 Pixel accepted on a rising edge where pix_valid and pix_ready are both 1; no other cycle alters the line buffers or counters.
REQ-019 Two line buffers of IMG_W entries and a 3x3 window register shall hold the last three rows; each accepted pixel shifts into the window and line buffers.
REQ-020 Column counter increments per accepted pixel and wraps IMG_W-1 -> 0, incrementing the row counter; the row counter saturates at 1023.
REQ-021 frame_start with an accepted pixel forces that pixel to row 0, col 0 (counters then advance from there); frame_start without acceptance is ignored.
REQ-022 Window produced only when the accepted pixel has row >= 2 and col >= 2; no border padding; (IMG_W-2) windows per row from row 2 on.
REQ-023 FSM states: IDLE (pix_ready=1, busy=0) and SERIAL (pix_ready=0, busy=1, tap counter k=0..8).
REQ-024 IDLE -> SERIAL on acceptance of a window-producing pixel; SERIAL -> IDLE after k=8; otherwise remain.
REQ-025 In SERIAL, one tap per cycle: act_out = window[k/3][k%3] (row 0 = oldest row, col 0 = oldest column), wgt_out = W[k], mac_valid=1.
REQ-026 First tap appears the cycle after acceptance; pix_ready returns to 1 the cycle after k=8; back-to-back windows thus take 10 cycles per pixel.
REQ-027 mac_first=1 only at k=0, mac_last=1 only at k=8; both 0 whenever mac_valid=0.
REQ-028 mac_valid=0 in IDLE; act_out and wgt_out hold 0 in IDLE.
REQ-029 Weight registers W[0..8] writable any cycle; wgt_addr 9..15 ignored.
REQ-030 On entering SERIAL, W[0..8] copied to a shadow set; all 9 taps of a window use the shadow; writes during SERIAL affect only later windows.
REQ-031 Window and weight values passed unmodified (raw DATA_W bits); signedness is the consumer's concern.

Reset
REQ-032 On reset: FSM IDLE, k=0, row=col=0, W[0..8]=0, shadow=0, mac_valid=mac_first=mac_last=busy=0, act_out=wgt_out=0, pix_ready=1.
REQ-033 Reset during SERIAL aborts the window immediately; no remaining taps emitted after deassertion.
REQ-034 Line buffer and window contents need not be reset; REQ-022 prevents stale data reaching the output.

Verification
REQ-035 IMG_W=4, W[0..8]=1, frame_start on first pixel, pixels 1..16 -> first window after pixel 11, taps 1,2,3,5,6,7,9,10,11; 4 windows, 36 mac_valid cycles total.
REQ-036 pix_valid held high throughout -> pix_ready low exactly 9 cycles after each window-producing acceptance; every pixel accepted exactly once, none lost.
REQ-037 Write W[4]=0x80 during tap 2 of a window -> that window's tap 4 uses old W[4]; next window's tap 4 shows wgt_out=0x80.
REQ-038 frame_start asserted at row 3 col 1 -> counters restart; no mac_valid until new frame's row 2 col 2 accepted.
REQ-039 Reset asserted at tap 5 -> mac_valid, busy, W[] all 0 immediately; pix_ready=1 after deassertion; next output is a fresh window starting with mac_first.
REQ-040 IMG_W=4 column wrap -> pixels at col 0 and col 1 of rows >= 2 produce no window; col 3 -> col 0 increments row.
